// File: rtl/self_output_requant_add_if.sv
// rtl/self_output_requant_add_if.sv - accumulator, residual and result stream bundle for the requant-add stage
interface self_output_requant_add_if #(
  parameter int LANES = 8,
  parameter int ACC_W = 32,
  parameter int OUT_W = 16
);
  logic                   acc_valid;
  logic                   acc_ready;
  logic [LANES*ACC_W-1:0] acc_data;
  logic                   res_valid;
  logic                   res_ready;
  logic [LANES*8-1:0]     res_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*OUT_W-1:0] out_data;
  logic                   out_last;
  logic                   out_tlast;

  // block side: consumes acc/res, produces results
  modport slave (
    input  acc_valid, acc_data, res_valid, res_data, out_ready,
    output acc_ready, res_ready, out_valid, out_data, out_last, out_tlast
  );

  // environment side: produces acc/res, consumes results
  modport master (
    output acc_valid, acc_data, res_valid, res_data, out_ready,
    input  acc_ready, res_ready, out_valid, out_data, out_last, out_tlast
  );
endinterface

// File: rtl/self_output_requant_add.sv
// rtl/self_output_requant_add.sv - bias add, (M,E) requant to int8, optional residual add, saturated result stream
module self_output_requant_add #(
  parameter int  LANES     = 8,
  parameter int  ACC_W     = 32,
  parameter int  M_W       = 32,
  parameter int  OUT_W     = 16,
  parameter int  EMBED_MAX = 768,
  localparam int DEPTH     = EMBED_MAX / LANES,
  localparam int ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_start,
  input  logic [15:0]                 i_cfg_tokens,
  input  logic [15:0]                 i_cfg_embed,
  input  logic [M_W-1:0]              i_requant_m,
  input  logic [7:0]                  i_requant_e,
  input  logic                        i_residual_en,
  input  logic                        i_bias_wr_en,
  input  logic [ADDR_W-1:0]           i_bias_wr_addr,
  input  logic [LANES*ACC_W-1:0]      i_bias_wr_data,
  self_output_requant_add_if.slave    bus,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_error
);
  localparam int S_W = ACC_W + 1;        // bias sum, never wraps
  localparam int P_W = ACC_W + M_W + 1;  // signed sum times unsigned multiplier
  localparam int R_W = P_W + 1;          // headroom so the rounding add cannot overflow

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;
  state_t r_state, w_next;

  logic [15:0]             r_row, r_row_last;
  logic [ADDR_W-1:0]       r_col, r_col_last;
  logic [M_W-1:0]          r_m;
  logic [5:0]              r_e;
  logic                    r_res_en, r_error, r_done;

  logic [LANES*ACC_W-1:0]  r_bias_mem [DEPTH];
  logic [LANES*ACC_W-1:0]  w_bias_row;

  logic                    w_cfg_ok, w_pipe_en, w_res_ok, w_fire;
  logic                    w_col_end, w_row_end, w_out_hs;

  logic signed [S_W-1:0]   w_sum     [LANES];
  logic signed [S_W-1:0]   r_s1_sum  [LANES];
  logic signed [7:0]       r_s1_res  [LANES];
  logic                    r_s1_valid, r_s1_last, r_s1_tlast;
  logic signed [P_W-1:0]   w_prod    [LANES];
  logic signed [P_W-1:0]   r_s2_prod [LANES];
  logic signed [7:0]       r_s2_res  [LANES];
  logic                    r_s2_valid, r_s2_last, r_s2_tlast;
  logic signed [R_W-1:0]   w_rnd     [LANES];
  logic signed [R_W-1:0]   w_q       [LANES];
  logic signed [7:0]       w_q8      [LANES];
  logic signed [8:0]       w_y       [LANES];
  logic [LANES*OUT_W-1:0]  w_out_data, r_out_data;
  logic                    r_out_valid, r_out_last, r_out_tlast;

  assign w_cfg_ok  = (i_cfg_tokens != 16'd0) && (i_cfg_embed >= 16'(LANES)) &&
                     ((i_cfg_embed % 16'(LANES)) == 16'd0) && (i_cfg_embed <= 16'(EMBED_MAX));
  assign w_pipe_en = !(r_out_valid && !bus.out_ready);
  assign w_res_ok  = bus.res_valid || !r_res_en;
  assign w_fire    = (r_state == S_RUN) && bus.acc_valid && w_res_ok && w_pipe_en;
  assign w_col_end = (r_col == r_col_last);
  assign w_row_end = (r_row == r_row_last);
  assign w_out_hs  = r_out_valid && bus.out_ready;
  assign w_bias_row = r_bias_mem[r_col];

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // next state: legal start -> RUN, last beat accepted -> DRAIN, tensor-final result taken -> IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start && w_cfg_ok) w_next = S_RUN;
      S_RUN:   if (w_fire && w_col_end && w_row_end) w_next = S_DRAIN;
      S_DRAIN: if (w_out_hs && r_out_tlast) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // state outputs: joint acc/res handshake, each ready looks only at its partner's valid
  always_comb begin
    o_busy        = (r_state != S_IDLE);
    bus.acc_ready = (r_state == S_RUN) && w_pipe_en && w_res_ok;
    bus.res_ready = (r_state == S_RUN) && w_pipe_en && bus.acc_valid && r_res_en;
  end

  // config latch, row/col counters, sticky error and done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row      <= '0;
      r_row_last <= '0;
      r_col      <= '0;
      r_col_last <= '0;
      r_m        <= '0;
      r_e        <= '0;
      r_res_en   <= 1'b0;
      r_error    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= (r_state == S_DRAIN) && w_out_hs && r_out_tlast;
      if (r_state == S_IDLE) begin
        if (i_start) begin
          if (w_cfg_ok) begin
            r_row_last <= i_cfg_tokens - 16'd1;
            r_col_last <= ADDR_W'(i_cfg_embed / 16'(LANES) - 16'd1);
            r_m        <= i_requant_m;
            r_e        <= (i_requant_e > 8'd63) ? 6'd63 : i_requant_e[5:0];
            r_res_en   <= i_residual_en;
            r_error    <= 1'b0;
            r_row      <= '0;
            r_col      <= '0;
          end else begin
            r_error <= 1'b1;
          end
        end
      end else if (i_start || i_bias_wr_en) begin
        r_error <= 1'b1;
      end
      if (w_fire) begin
        if (w_col_end) begin
          r_col <= '0;
          r_row <= r_row + 16'd1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  // bias RAM: loaded only between tensors, contents survive reset
  always_ff @(posedge clk) begin
    if (i_bias_wr_en && (r_state == S_IDLE)) r_bias_mem[i_bias_wr_addr] <= i_bias_wr_data;
  end

  // stage 1 math: widen and add the column bias
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_sum[l] = S_W'($signed(bus.acc_data[l*ACC_W +: ACC_W])) +
                 S_W'($signed(w_bias_row[l*ACC_W +: ACC_W]));
    end
  end

  // stage 2 math: signed sum times unsigned multiplier
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_prod[l] = P_W'(r_s1_sum[l]) * $signed({{(P_W-M_W){1'b0}}, r_m});
    end
  end

  // stage 3 math: round half up, shift, clamp to int8, add residual, sign-extend
  always_comb begin
    w_out_data = '0;
    for (int l = 0; l < LANES; l++) begin
      w_rnd[l] = R_W'(r_s2_prod[l]);
      if (r_e != 6'd0) w_rnd[l] = w_rnd[l] + (R_W'(1) <<< (r_e - 6'd1));
      w_q[l] = w_rnd[l] >>> r_e;
      if (!w_q[l][R_W-1] && (|w_q[l][R_W-2:7]))     w_q8[l] = 8'h7f;
      else if (w_q[l][R_W-1] && !(&w_q[l][R_W-2:7])) w_q8[l] = 8'h80;
      else                                           w_q8[l] = w_q[l][7:0];
      w_y[l] = {w_q8[l][7], w_q8[l]} + {r_s2_res[l][7], r_s2_res[l]};
      w_out_data[l*OUT_W +: OUT_W] = OUT_W'(w_y[l]);
    end
  end

  // three-stage pipe, frozen as a whole while the output is held off
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_last   <= 1'b0;
      r_s1_tlast  <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_s2_last   <= 1'b0;
      r_s2_tlast  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_tlast <= 1'b0;
      r_out_data  <= '0;
      for (int l = 0; l < LANES; l++) begin
        r_s1_sum[l]  <= '0;
        r_s1_res[l]  <= '0;
        r_s2_prod[l] <= '0;
        r_s2_res[l]  <= '0;
      end
    end else if (w_pipe_en) begin
      r_s1_valid  <= w_fire;
      r_s1_last   <= w_fire && w_col_end;
      r_s1_tlast  <= w_fire && w_col_end && w_row_end;
      r_s2_valid  <= r_s1_valid;
      r_s2_last   <= r_s1_last;
      r_s2_tlast  <= r_s1_tlast;
      r_out_valid <= r_s2_valid;
      r_out_last  <= r_s2_last;
      r_out_tlast <= r_s2_tlast;
      r_out_data  <= w_out_data;
      for (int l = 0; l < LANES; l++) begin
        r_s1_sum[l]  <= w_sum[l];
        r_s1_res[l]  <= r_res_en ? $signed(bus.res_data[l*8 +: 8]) : 8'sd0;
        r_s2_prod[l] <= w_prod[l];
        r_s2_res[l]  <= r_s1_res[l];
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;
  assign bus.out_tlast = r_out_tlast;
  assign o_done        = r_done;
  assign o_error       = r_error;
endmodule
